// File: rtl/svd_host_sequencer_if.sv
// Bus between the host sequencer (master) and the 2x2 CORDIC SVD interface block (slave):
// the 5-bit half-word write path, the oe/element_sel readback path and the result ready flag.
interface svd_host_sequencer_if;
  logic       svd_we;
  logic       svd_oe;
  logic [4:0] svd_data;
  logic [1:0] svd_sel;
  logic       svd_ready;
  logic [7:0] svd_uv;
  logic [6:0] svd_s;

  modport master (
    output svd_we, svd_oe, svd_data, svd_sel,
    input  svd_ready, svd_uv, svd_s
  );

  modport slave (
    input  svd_we, svd_oe, svd_data, svd_sel,
    output svd_ready, svd_uv, svd_s
  );
endinterface

// File: rtl/svd_host_sequencer.sv
// Host-side sequencer for the 2x2 CORDIC SVD block: loads a matrix as 8 half-words, waits for
// the result and reads U/V and S back. Optional WAIT timeout/abort enabled by SVD_SEQ_TIMEOUT_EN.
module svd_host_sequencer #(
  parameter int RD_HOLD    = 2,
  parameter int ARM_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [39:0]                 in_matrix,
  svd_host_sequencer_if.master        svd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_uv,
  output logic [27:0]                 out_s,
  output logic                        busy,
  output logic                        err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ARM  = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] READ = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [7:0] ARM_LAST   = 8'(ARM_CYCLES - 1);
  localparam logic [7:0] HOLD0_LAST = 8'(RD_HOLD);
  localparam logic [7:0] HOLDN_LAST = 8'(RD_HOLD - 1);

  logic [2:0]  state_q, state_d;
  logic [39:0] mat_q, mat_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  slot_q, slot_d;
  logic        we_q, we_d;
  logic        oe_q, oe_d;
  logic [4:0]  data_q, data_d;
  logic [1:0]  sel_q, sel_d;
  logic        vld_q, vld_d;
  logic [31:0] uv_q, uv_d;
  logic [27:0] s_q, s_d;

`ifdef SVD_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  logic [2:0]  idx_nxt;
  logic [9:0]  elem;
  logic [7:0]  hold_last;

  assign idx_nxt   = idx_q + 3'd1;
  assign hold_last = (slot_q == 2'd0) ? HOLD0_LAST : HOLDN_LAST;

  always_comb begin
    elem = mat_q[9:0];
    case (idx_nxt[2:1])
      2'd0: elem = mat_q[9:0];
      2'd1: elem = mat_q[19:10];
      2'd2: elem = mat_q[29:20];
      2'd3: elem = mat_q[39:30];
      default: elem = mat_q[9:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    we_d    = we_q;
    oe_d    = oe_q;
    data_d  = data_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    uv_d    = uv_q;
    s_d     = s_q;
`ifdef SVD_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mat_d   = in_matrix;
          state_d = LOAD;
          idx_d   = 3'd0;
          we_d    = 1'b1;
          sel_d   = 2'd0;
          data_d  = in_matrix[4:0];
`ifdef SVD_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (idx_q == 3'd7) begin
          state_d = ARM;
          we_d    = 1'b0;
          data_d  = 5'd0;
          sel_d   = 2'd0;
          cnt_d   = 8'd0;
        end else begin
          // Even index carries the low half of the element, odd index the high half.
          idx_d  = idx_nxt;
          sel_d  = idx_nxt[2:1];
          data_d = idx_nxt[0] ? elem[9:5] : elem[4:0];
        end
      end
      ARM: begin
        if (cnt_q == ARM_LAST) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
`ifdef SVD_SEQ_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (svd.svd_ready) begin
          state_d = READ;
          oe_d    = 1'b1;
          sel_d   = 2'd0;
          slot_d  = 2'd0;
          cnt_d   = 8'd0;
        end
`ifdef SVD_SEQ_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      READ: begin
        // Capture on the final cycle of each hold so the slave output has settled longest.
        if (cnt_q == hold_last) begin
          case (slot_q)
            2'd0: begin uv_d[7:0]   = svd.svd_uv; s_d[6:0]   = svd.svd_s; end
            2'd1: begin uv_d[15:8]  = svd.svd_uv; s_d[13:7]  = svd.svd_s; end
            2'd2: begin uv_d[23:16] = svd.svd_uv; s_d[20:14] = svd.svd_s; end
            default: begin uv_d[31:24] = svd.svd_uv; s_d[27:21] = svd.svd_s; end
          endcase
          cnt_d = 8'd0;
          if (slot_q == 2'd3) begin
            state_d = DONE;
            oe_d    = 1'b0;
            sel_d   = 2'd0;
            vld_d   = 1'b1;
          end else begin
            slot_d = slot_q + 2'd1;
            sel_d  = slot_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        data_d  = 5'd0;
        sel_d   = 2'd0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      uv_q    <= '0;
      s_q     <= '0;
`ifdef SVD_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      uv_q    <= uv_d;
      s_q     <= s_d;
`ifdef SVD_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign svd.svd_we   = we_q;
  assign svd.svd_oe   = oe_q;
  assign svd.svd_data = data_q;
  assign svd.svd_sel  = sel_q;
  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = vld_q;
  assign out_uv       = uv_q;
  assign out_s        = s_q;
`ifdef SVD_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_svd_host_sequencer.sv
// Scoreboard bench for svd_host_sequencer: stimulus pushes expected load words, readback
// selects and result words; a negedge monitor pops and compares whenever the DUT presents them.
module tb_svd_host_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_matrix = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_uv;
  logic [27:0] out_s;
  logic        busy;
  logic        err;

  logic        rdy_drv = 1'b1;
  logic [7:0]  uv_base = 8'h10;
  logic [6:0]  s_base  = 7'h20;

  always #5 clk = ~clk;

  svd_host_sequencer_if bus();

  // Behavioural slave: element k reads back as base+k while oe is high.
  assign bus.svd_ready = rdy_drv;
  assign bus.svd_uv    = bus.svd_oe ? (uv_base + {6'd0, bus.svd_sel}) : 8'hEE;
  assign bus.svd_s     = bus.svd_oe ? (s_base + {5'd0, bus.svd_sel}) : 7'h6E;

  svd_host_sequencer #(.RD_HOLD(2), .ARM_CYCLES(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_matrix (in_matrix),
    .svd       (bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uv    (out_uv),
    .out_s     (out_s),
    .busy      (busy),
    .err       (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int load_seen = 0;
  int oe_seen = 0;

  logic [6:0]  load_q[$];
  logic [1:0]  rd_q[$];
  logic [59:0] res_q[$];

  // Matrices: {a11,a10,a01,a00}, Q8.2 10-bit.
  // M1 = {-28.0,-56.0,-31.0,+43.0} -> {0x390,0x320,0x384,0x0AC}
  localparam logic [39:0] M1 = {10'h390, 10'h320, 10'h384, 10'h0AC};
  localparam logic [39:0] M2 = {10'h155, 10'h2AA, 10'h01F, 10'h3E0};
  localparam logic [39:0] M3 = {10'h200, 10'h1FF, 10'h001, 10'h000};
  // Expected half-words, word 7 leftmost.
  localparam logic [39:0] H1 = {5'b11100, 5'b10000, 5'b11001, 5'b00000,
                                5'b11100, 5'b00100, 5'b00101, 5'b01100};
  localparam logic [39:0] H2 = {5'b01010, 5'b10101, 5'b10101, 5'b01010,
                                5'b00000, 5'b11111, 5'b11111, 5'b00000};
  localparam logic [39:0] H3 = {5'b10000, 5'b00000, 5'b01111, 5'b11111,
                                5'b00000, 5'b00001, 5'b00000, 5'b00000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.svd_we) begin
        load_seen++;
        if (load_q.size() == 0) chk("load_unexpected", 64'd1, 64'd0);
        else chk("load_word", {57'd0, bus.svd_sel, bus.svd_data}, {57'd0, load_q.pop_front()});
      end
      if (bus.svd_oe) begin
        oe_seen++;
        if (rd_q.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
        else chk("read_sel", {62'd0, bus.svd_sel}, {62'd0, rd_q.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (res_q.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
        else chk("result", {4'd0, out_uv, out_s}, {4'd0, res_q.pop_front()});
      end
    end
  end

  task automatic push_load(input logic [39:0] h);
    for (int i = 0; i < 8; i++) load_q.push_back({2'(i >> 1), h[i*5 +: 5]});
  endtask

  task automatic push_read(input logic [31:0] uv, input logic [27:0] s);
    rd_q.push_back(2'd0); rd_q.push_back(2'd0); rd_q.push_back(2'd0);
    rd_q.push_back(2'd1); rd_q.push_back(2'd1);
    rd_q.push_back(2'd2); rd_q.push_back(2'd2);
    rd_q.push_back(2'd3); rd_q.push_back(2'd3);
    res_q.push_back({uv, s});
  endtask

  // Returns just after the accept edge.
  task automatic send(input logic [39:0] m);
    bit ok;
    ok = 0;
    in_matrix = m;
    in_valid  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    bit ok;
    ok = 0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 cyc++;
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(bus.svd_we), 64'd0);
    chk("rst_oe", 64'(bus.svd_oe), 64'd0);
    chk("rst_data_sel", {57'd0, bus.svd_data, bus.svd_sel}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out", {3'd0, out_valid, out_uv, out_s}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b1;

    // Async reset in the middle of LOAD (word 3 on the bus)
    load_seen = 0;
    push_load(H1);
    send(M1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (load_seen == 4) begin ok = 1; break; end
    end
    chk("midload_reached", 64'(ok), 64'd1);
    rst = 1'b0;
    #1;
    chk("midload_we", 64'(bus.svd_we), 64'd0);
    chk("midload_data_sel", {57'd0, bus.svd_data, bus.svd_sel}, 64'd0);
    chk("midload_in_ready", 64'(in_ready), 64'd1);
    chk("midload_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    load_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("after_reset_idle", {61'd0, out_valid, bus.svd_we, in_ready}, 64'd1);

    // M1: ready high throughout, no backpressure
    load_seen = 0;
    oe_seen = 0;
    push_load(H1);
    push_read(32'h13121110, {7'h23, 7'h22, 7'h21, 7'h20});
    send(M1);
    wait_out(cyc);
    chk("latency_m1", 64'(cyc), 64'd20);
    @(posedge clk);
    #1;
    chk("m1_we_cycles", 64'(load_seen), 64'd8);
    chk("m1_oe_cycles", 64'(oe_seen), 64'd9);
    chk("m1_back_idle", {62'd0, out_valid, in_ready}, 64'd1);

    // M2 under 5 cycles of backpressure with in_valid held high
    out_ready = 1'b0;
    uv_base = 8'hA0;
    s_base  = 7'h50;
    push_load(H2);
    push_read(32'hA3A2A1A0, {7'h53, 7'h52, 7'h51, 7'h50});
    send(M2);
    in_valid  = 1'b1;
    in_matrix = M3;
    wait_out(cyc);
    chk("latency_m2", 64'(cyc), 64'd20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_uv", 64'(out_uv), 64'h00000000A3A2A1A0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {62'd0, out_valid, in_ready}, 64'd1);

    // M3 accepted from the held request; svd_ready low keeps WAIT
    rdy_drv = 1'b0;
    uv_base = 8'h70;
    s_base  = 7'h08;
    load_seen = 0;
    push_load(H3);
    push_read(32'h73727170, {7'h0B, 7'h0A, 7'h09, 7'h08});
    send(M3);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (load_seen == 8) begin ok = 1; break; end
    end
    chk("m3_loaded", 64'(ok), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("wait_hold", {61'd0, bus.svd_oe, out_valid, busy}, 64'd1);
    rdy_drv = 1'b1;
    wait_out(cyc);
    chk("latency_from_ready", 64'(cyc), 64'd10);
    @(posedge clk);
    #1;
    chk("m3_back_idle", 64'(in_ready), 64'd1);

`ifdef SVD_SEQ_TIMEOUT_EN
    // Timeout with svd_ready stuck low: 8 load + 2 arm + 16 wait cycles
    rdy_drv = 1'b0;
    push_load(H1);
    send(M1);
    ok = 0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 cyc++;
      if (!busy) begin ok = 1; break; end
    end
    chk("tmo_reached_idle", 64'(ok), 64'd1);
    chk("tmo_cycles", 64'(cyc), 64'd26);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_no_valid", 64'(out_valid), 64'd0);
    rdy_drv = 1'b1;
    uv_base = 8'h10;
    s_base  = 7'h20;
    push_load(H2);
    push_read(32'h13121110, {7'h23, 7'h22, 7'h21, 7'h20});
    send(M2);
    chk("tmo_err_cleared", 64'(err), 64'd0);
    wait_out(cyc);
    chk("latency_after_tmo", 64'(cyc), 64'd20);
    @(posedge clk);
    #1;
`else
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("load_q_drained", 64'(load_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("res_q_drained", 64'(res_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
